multicycle_controller: RTL and testbench

- Control unit for the multicycle RV32 datapath; the producer side of the ALU's ALUControl interface.
- A Moore FSM sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, lui, beq and jal.
- Drives the datapath mux selects, write enables and the 3-bit ALUControl consumed by the ALU.
- Takes the ALU's Zero flag back for branch resolution.

---
 rtl/riscv_pkg.sv | 71 +++++++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32 control path.
// Opcodes, FSM states, ALU controls and datapath mux selects.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_EXECUTEU,
      S_ALUWB,
      S_BRANCH,
      S_JAL
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_AND   = 3'b010,
      ALU_OR    = 3'b011,
      ALU_PASSB = 3'b100,
      ALU_SLT   = 3'b101
   } alu_ctrl_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_PASSB = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Immediate format follows the opcode directly, independent of state.
   function automatic logic [2:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         OP_LUI:  return IMM_U;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/funct decode into the 3-bit ALUControl.
// Ports: i_alu_op, i_funct3, i_funct7b5, i_op5 in; o_alu_control out.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [2:0] o_alu_control
);

   // funct7b5 only means sub for register-register ops (op[5]=1).
   logic w_sub;
   assign w_sub = i_op5 & i_funct7b5;

   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_alu_op)
         ALUOP_ADD:   o_alu_control = ALU_ADD;
         ALUOP_SUB:   o_alu_control = ALU_SUB;
         ALUOP_PASSB: o_alu_control = ALU_PASSB;
         default: begin
            case (i_funct3)
               3'b000:  o_alu_control = w_sub ? ALU_SUB : ALU_ADD;
               3'b010:  o_alu_control = ALU_SLT;
               3'b110:  o_alu_control = ALU_OR;
               3'b111:  o_alu_control = ALU_AND;
               default: o_alu_control = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle RV32 datapath.
// Ports: clk, reset, op, funct3, funct7b5, Zero in; datapath
// enables, mux selects, ALUControl and IllegalInstr out.
// Build option BNE_EN: BRANCH also redirects on bne (funct3=001).
module multicycle_controller
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       IllegalInstr
);

   state_t     r_state;
   state_t     w_next;
   logic [1:0] w_alu_op;
   logic       w_pc_update;
   logic       w_branch;
   logic       w_taken;
   logic       w_illegal;

`ifdef BNE_EN
   assign w_taken = (funct3 == 3'b000) ? Zero :
                    (funct3 == 3'b001) ? ~Zero : 1'b0;
`else
   assign w_taken = Zero & (funct3 == 3'b000);
`endif

   assign w_illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I,
                                   OP_LUI, OP_BEQ, OP_JAL});

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_LUI:       w_next = S_EXECUTEU;
               OP_BEQ:       w_next = S_BRANCH;
               OP_JAL:       w_next = S_JAL;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_EXECUTEU: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      ResultSrc    = RES_ALUOUT;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RS2;
      IllegalInstr = 1'b0;
      w_alu_op     = ALUOP_ADD;
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      case (r_state)
         S_FETCH: begin
            IRWrite     = 1'b1;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALURESULT;
            w_pc_update = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_IMM;
            IllegalInstr = w_illegal;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA  = SRCA_RS1;
            w_alu_op = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            w_alu_op = ALUOP_FUNCT;
         end
         S_EXECUTEU: begin
            ALUSrcB  = SRCB_IMM;
            w_alu_op = ALUOP_PASSB;
         end
         S_ALUWB: RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA  = SRCA_RS1;
            w_alu_op = ALUOP_SUB;
            w_branch = 1'b1;
         end
         S_JAL: begin
            ALUSrcA     = SRCA_OLDPC;
            ALUSrcB     = SRCB_FOUR;
            w_pc_update = 1'b1;
         end
         default: ;
      endcase
      // Reset masks every enable so an interrupted instruction
      // leaves no architectural side effect.
      if (reset) begin
         MemWrite     = 1'b0;
         IRWrite      = 1'b0;
         RegWrite     = 1'b0;
         IllegalInstr = 1'b0;
      end
   end

   assign PCWrite = (w_pc_update | (w_branch & w_taken)) & ~reset;
   assign ImmSrc  = imm_src(op);

   alu_decoder u_alu_dec (
      .i_alu_op      (w_alu_op),
      .i_funct3      (funct3),
      .i_funct7b5    (funct7b5),
      .i_op5         (op[5]),
      .o_alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Per-instruction cycle model plus literal spot checks.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUControl;
   logic       IllegalInstr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk          (clk),
      .reset        (reset),
      .op           (op),
      .funct3       (funct3),
      .funct7b5     (funct7b5),
      .Zero         (Zero),
      .PCWrite      (PCWrite),
      .AdrSrc       (AdrSrc),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .RegWrite     (RegWrite),
      .ResultSrc    (ResultSrc),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ImmSrc       (ImmSrc),
      .ALUControl   (ALUControl),
      .IllegalInstr (IllegalInstr)
   );

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] res;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [2:0] imm;
      logic [2:0] alu;
      logic       ill;
   } exp_t;

   exp_t  q[$];
   string tag;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Register-format ALU function as the ISA defines it.
   function automatic logic [2:0] fn_alu(input logic [6:0] o,
                                         input logic [2:0] f3,
                                         input logic f7);
      if (f3 == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
      if (f3 == 3'd2) return 3'd5;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd7) return 3'd2;
      return 3'd0;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3,
                                     input logic z);
      if (f3 == 3'd0) return z;
`ifdef BNE_EN
      if (f3 == 3'd1) return !z;
`endif
      return 1'b0;
   endfunction

   // Builds the full cycle-by-cycle output list for one instruction
   // and queues up to 'lim' of its cycles.
   task automatic push_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z,
                             input int lim);
      exp_t s[$];
      exp_t e;
      logic [2:0] im;
      case (o)
         7'b0100011: im = 3'd1;
         7'b1100011: im = 3'd2;
         7'b1101111: im = 3'd3;
         7'b0110111: im = 3'd4;
         default:    im = 3'd0;
      endcase
      e = '0; e.irw = 1; e.pcw = 1; e.srcb = 2; e.res = 2;
      s.push_back(e);
      e = '0; e.srca = 1; e.srcb = 1;
      e.ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b0110111, 7'b1100011,
                          7'b1101111});
      s.push_back(e);
      case (o)
         7'b0000011, 7'b0100011: begin
            e = '0; e.srca = 2; e.srcb = 1; s.push_back(e);
            if (o[5]) begin
               e = '0; e.adr = 1; e.memw = 1; s.push_back(e);
            end else begin
               e = '0; e.adr = 1; s.push_back(e);
               e = '0; e.res = 1; e.regw = 1; s.push_back(e);
            end
         end
         7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111: begin
            e = '0;
            if (o == 7'b0110111) begin
               e.srcb = 1; e.alu = 3'd4;
            end else if (o == 7'b1101111) begin
               e.srca = 1; e.srcb = 2; e.pcw = 1;
            end else begin
               e.srca = 2; e.srcb = o[5] ? 2'd0 : 2'd1;
               e.alu = fn_alu(o, f3, f7);
            end
            s.push_back(e);
            e = '0; e.regw = 1; s.push_back(e);
         end
         7'b1100011: begin
            e = '0; e.srca = 2; e.alu = 3'd1;
            e.pcw = br_taken(f3, z);
            s.push_back(e);
         end
         default: ;
      endcase
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      tag = $sformatf("op%b_f%0d_z%0d", o, f3, z);
      for (int i = 0; i < s.size() && i < lim; i++) begin
         e = s[i];
         e.imm = im;
         q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic run(input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
      push_instr(o, f3, f7, z, 99);
      wait_idle();
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (q.size() != 0) begin
         e = q.pop_front();
         a = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
              ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
              IllegalInstr};
         chk({"cyc_", tag}, int'(a), int'(e));
      end
   end

   initial begin
      reset = 1; op = 7'b0110011; funct3 = 0; funct7b5 = 1; Zero = 0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_we", {PCWrite, MemWrite, IRWrite, RegWrite,
                        IllegalInstr}, 0);
      end
      reset = 0;
      // sub: literal spot checks on the model's key points
      push_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 99);
      @(negedge clk);
      chk("fetch_irw", IRWrite, 1);
      chk("fetch_pcw", PCWrite, 1);
      chk("fetch_alu", ALUControl, 0);
      @(negedge clk);
      @(negedge clk);
      chk("sub_alu", ALUControl, 3'b001);
      @(negedge clk);
      chk("sub_wb", RegWrite, 1);
      wait_idle();

      push_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 99);
      @(negedge clk);
      chk("lw_imm", ImmSrc, 0);
      repeat (4) @(negedge clk);
      chk("lw_wb", {RegWrite, ResultSrc}, 3'b101);
      wait_idle();

      run(7'b0100011, 3'd2, 1'b0, 1'b0);

      push_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 99);
      repeat (3) @(negedge clk);
      chk("beq_taken", PCWrite, 1);
      wait_idle();
      push_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 99);
      repeat (3) @(negedge clk);
      chk("beq_not", PCWrite, 0);
      wait_idle();
      push_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 99);
      repeat (3) @(negedge clk);
`ifdef BNE_EN
      chk("bne_taken", PCWrite, 1);
`else
      chk("bne_off", PCWrite, 0);
`endif
      wait_idle();
      run(7'b1100011, 3'd1, 1'b0, 1'b1);
      run(7'b1100011, 3'd4, 1'b0, 1'b1);

      push_instr(7'b0110111, 3'd5, 1'b1, 1'b0, 99);
      repeat (3) @(negedge clk);
      chk("lui_alu", ALUControl, 3'b100);
      chk("lui_imm", ImmSrc, 3'b100);
      @(negedge clk);
      chk("lui_wb", RegWrite, 1);
      wait_idle();

      run(7'b0010011, 3'd0, 1'b1, 1'b0);
      run(7'b0010011, 3'd2, 1'b0, 1'b0);
      run(7'b0010011, 3'd6, 1'b0, 1'b0);
      run(7'b0010011, 3'd7, 1'b0, 1'b0);
      run(7'b0110011, 3'd0, 1'b0, 1'b0);
      run(7'b0110011, 3'd7, 1'b0, 1'b0);
      run(7'b0110011, 3'd6, 1'b0, 1'b0);
      run(7'b0110011, 3'd2, 1'b0, 1'b0);
      run(7'b0110011, 3'd1, 1'b1, 1'b0);
      run(7'b1101111, 3'd3, 1'b0, 1'b1);

      push_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 99);
      repeat (2) @(negedge clk);
      chk("illegal", IllegalInstr, 1);
      wait_idle();
      run(7'b0000011, 3'd2, 1'b0, 1'b0);

      // sw stopped by reset while in its store cycle
      push_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3);
      wait_idle();
      reset = 1;
      @(negedge clk);
      chk("rst_sw_memw", MemWrite, 0);
      chk("rst_sw_adr", AdrSrc, 1);
      @(posedge clk); #1;
      reset = 0;
      run(7'b0110111, 3'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
